// File: rtl/attention_output_projection.sv
// attention_output_projection
// Output projection stage of the self-attention block: Y = Z*WO + bO (+ x).
// One signed MAC per cycle, sequenced by an IDLE/MAC/WB state machine and
// driven by the shared start/done/out_valid handshake.
// Build option: define RESIDUAL_ADD_EN to add the residual input x before rounding.
module attention_output_projection #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC       = 8,
    parameter int L          = 8,
    parameter int N          = 1,
    parameter int E          = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+$clog2(E)+2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         done,
    input  logic [DATA_WIDTH*L*N*E-1:0]  z_in,
    input  logic [DATA_WIDTH*L*N*E-1:0]  x_in,
    input  logic [DATA_WIDTH*E*E-1:0]    WO_in,
    input  logic [DATA_WIDTH*E-1:0]      bO_in,
    output logic [DATA_WIDTH*L*N*E-1:0]  y_out,
    output logic                         out_valid
);

    localparam int RN = L*N;
    localparam int RW = (RN > 1) ? $clog2(RN) : 1;
    localparam int EW = (E > 1) ? $clog2(E) : 1;
    localparam int PW = 2*DATA_WIDTH;

    localparam logic [RW-1:0] R_LAST = RW'(RN-1);
    localparam logic [EW-1:0] K_LAST = EW'(E-1);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] ROUND_HALF =
        {{(ACC_WIDTH-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        WB
    } state_t;

    state_t state;

    logic signed [DATA_WIDTH-1:0] z_unp  [RN][E];
    logic signed [DATA_WIDTH-1:0] z_mem  [RN][E];
    logic signed [DATA_WIDTH-1:0] wo_unp [E][E];
    logic signed [DATA_WIDTH-1:0] wo_mem [E][E];
    logic signed [DATA_WIDTH-1:0] bo_unp [E];
    logic signed [DATA_WIDTH-1:0] bo_mem [E];
    logic signed [DATA_WIDTH-1:0] y_mem  [RN][E];
`ifdef RESIDUAL_ADD_EN
    logic signed [DATA_WIDTH-1:0] x_unp  [RN][E];
    logic signed [DATA_WIDTH-1:0] x_mem  [RN][E];
`else
    logic unused_x_in;
    assign unused_x_in = ^x_in;
`endif

    logic [RW-1:0]                r;
    logic [EW-1:0]                j;
    logic [EW-1:0]                k;
    logic signed [ACC_WIDTH-1:0]  acc;

    // Flat port vectors <-> element arrays
    for (genvar gr = 0; gr < RN; gr++) begin : g_row
        for (genvar ge = 0; ge < E; ge++) begin : g_col
            assign z_unp[gr][ge] = z_in[(gr*E+ge)*DATA_WIDTH +: DATA_WIDTH];
            assign y_out[(gr*E+ge)*DATA_WIDTH +: DATA_WIDTH] = y_mem[gr][ge];
`ifdef RESIDUAL_ADD_EN
            assign x_unp[gr][ge] = x_in[(gr*E+ge)*DATA_WIDTH +: DATA_WIDTH];
`endif
        end
    end

    for (genvar gi = 0; gi < E; gi++) begin : g_wrow
        assign bo_unp[gi] = bO_in[gi*DATA_WIDTH +: DATA_WIDTH];
        for (genvar gj = 0; gj < E; gj++) begin : g_wcol
            assign wo_unp[gi][gj] = WO_in[(gi*E+gj)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    logic signed [PW-1:0]         z_ext;
    logic signed [PW-1:0]         w_ext;
    logic signed [PW-1:0]         prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  bias_ext;
    logic signed [ACC_WIDTH-1:0]  res_ext;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH-1:0]  rnd;
    logic signed [DATA_WIDTH-1:0] y_sat;

    // MAC product and write-back rounding/saturation datapath
    always_comb begin
        z_ext    = {{(PW-DATA_WIDTH){z_mem[r][k][DATA_WIDTH-1]}}, z_mem[r][k]};
        w_ext    = {{(PW-DATA_WIDTH){wo_mem[k][j][DATA_WIDTH-1]}}, wo_mem[k][j]};
        prod     = z_ext * w_ext;
        prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
        bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bo_mem[j][DATA_WIDTH-1]}}, bo_mem[j]};
`ifdef RESIDUAL_ADD_EN
        res_ext  = {{(ACC_WIDTH-DATA_WIDTH){x_mem[r][j][DATA_WIDTH-1]}}, x_mem[r][j]};
`else
        res_ext  = '0;
`endif
        sum = acc + (bias_ext <<< FRAC) + (res_ext <<< FRAC) + ROUND_HALF;
        rnd = sum >>> FRAC;
        if (rnd > SAT_MAX) begin
            y_sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (rnd < SAT_MIN) begin
            y_sat = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            y_sat = rnd[DATA_WIDTH-1:0];
        end
    end

    // Control FSM, operand latches, accumulator and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            done      <= 1'b0;
            out_valid <= 1'b0;
            r         <= '0;
            j         <= '0;
            k         <= '0;
            acc       <= '0;
            z_mem     <= '{default: '0};
            wo_mem    <= '{default: '0};
            bo_mem    <= '{default: '0};
            y_mem     <= '{default: '0};
`ifdef RESIDUAL_ADD_EN
            x_mem     <= '{default: '0};
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        z_mem     <= z_unp;
                        wo_mem    <= wo_unp;
                        bo_mem    <= bo_unp;
`ifdef RESIDUAL_ADD_EN
                        x_mem     <= x_unp;
`endif
                        r         <= '0;
                        j         <= '0;
                        k         <= '0;
                        acc       <= '0;
                        out_valid <= 1'b0;
                        state     <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    if (k == K_LAST) begin
                        state <= WB;
                    end else begin
                        k <= k + EW'(1);
                    end
                end
                WB: begin
                    y_mem[r][j] <= y_sat;
                    acc         <= '0;
                    k           <= '0;
                    if (j == K_LAST) begin
                        j <= '0;
                        if (r == R_LAST) begin
                            r         <= '0;
                            done      <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            r     <= r + RW'(1);
                            state <= MAC;
                        end
                    end else begin
                        j     <= j + EW'(1);
                        state <= MAC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
